cordic_feed: RTL and testbench

Front-end stage of the CORDIC rotation pipeline; sits directly upstream of the first cordic_stage.
- Accepts phase angles from the oscillator/phase-accumulator over a valid/ready handshake.
- Folds each angle into the convergence range [-pi/2, pi/2] and emits the initial k/c/x/y/z/valid vector that the first stage consumes.
- The stage chain has no backpressure, so a credit counter limits in-flight samples to the depth of the downstream output FIFO.

---
 rtl/cordic_pkg.sv | 31 +++
 rtl/cordic_credit_counter.sv | 45 ++++
 rtl/cordic_feed.sv | 117 +++++++++++
 tb/tb_cordic_feed.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared CORDIC constants and types for the feed stage and the rotation stage chain.
// Latency: n/a (types, constants and one combinational helper).
// Backpressure: n/a.
// Angles are binary angle units: full circle = 2^16, 0x4000 = pi/2, 0x8000 = -pi.
package cordic_pkg;

    typedef logic [15:0] angle_t;
    typedef logic [15:0] sample_t;

    localparam angle_t ANGLE_HALF_PI   = 16'h4000;
    localparam angle_t ANGLE_PI        = 16'h8000;
    localparam angle_t ANGLE_3HALF_PI  = 16'hC000;

    // 1/1.64676 in Q1.15 (19898), pre-compensates the chain's CORDIC gain.
    localparam sample_t CORDIC_GAIN_INV = 16'h4DBA;

    // atan(2^-i) in binary angle units, one entry per rotation stage.
    localparam angle_t ATAN_TABLE [16] = '{
        16'h2000, 16'h12E4, 16'h09FB, 16'h0511,
        16'h028B, 16'h0146, 16'h00A3, 16'h0051,
        16'h0029, 16'h0014, 16'h000A, 16'h0005,
        16'h0003, 16'h0001, 16'h0001, 16'h0000
    };

    // Angles strictly between pi/2 and 3pi/2 lie outside the convergence
    // range; the boundaries themselves converge and are left alone.
    function automatic logic needs_fold(input angle_t a);
        return (a > ANGLE_HALF_PI) && (a < ANGLE_3HALF_PI);
    endfunction

endpackage

// File: rtl/cordic_credit_counter.sv
// Credit counter bounding samples in flight into a non-stalling pipeline.
// Latency: in_ready follows a take/give by one cycle (registered count only).
// Backpressure: o_ready drops when all credits are consumed; surplus returns set a sticky error.
// Ports: clock, reset_n (async active-low); i_take (accept), i_give (credit return pulse);
//        o_ready (credits available), o_err (sticky over-return).
module cordic_credit_counter #(
    parameter int CREDITS = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_take,
    input  logic i_give,
    output logic o_ready,
    output logic o_err
);

    localparam logic [7:0] FULL = 8'(CREDITS);

    logic [7:0] r_count;
    logic       r_err;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= FULL;
            r_err   <= 1'b0;
        end else begin
            // Simultaneous take and give cancel out.
            if (i_take && !i_give) begin
                if (r_count != 8'd0) begin
                    r_count <= r_count - 8'd1;
                end
            end else if (i_give && !i_take) begin
                if (r_count == FULL) begin
                    r_err <= 1'b1;
                end else begin
                    r_count <= r_count + 8'd1;
                end
            end
        end
    end

    assign o_ready = (r_count != 8'd0);
    assign o_err   = r_err;

endmodule

// File: rtl/cordic_feed.sv
// CORDIC front end: folds the phase into [-pi/2, pi/2] and emits the first-stage k/c/x/y/z vector.
// Latency: sample accepted at edge N appears on valid_out after edge N+2; never stalls.
// Backpressure: in_ready is gated by a credit counter sized to the downstream output FIFO.
// Ports: clock, reset_n (async active-low); in_angle/in_valid/in_ready handshake;
//        credit_return pulse; k/c/x/y/z_out + valid_out to the first stage; credit_err sticky.
// Option: define CORDIC_FEED_DITHER_EN to add LFSR dither (-2..+1) to the angle on accept.
module cordic_feed
    import cordic_pkg::*;
#(
    parameter sample_t AMPLITUDE = CORDIC_GAIN_INV,
    parameter angle_t  C0        = ATAN_TABLE[0],
    parameter int      CREDITS   = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] in_angle,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        credit_return,
    output logic [15:0] k_out,
    output logic [15:0] c_out,
    output logic [15:0] x_out,
    output logic [15:0] y_out,
    output logic [15:0] z_out,
    output logic        valid_out,
    output logic        credit_err
);

    logic   w_accept;
    angle_t w_angle;

    assign w_accept = in_valid && in_ready;

    cordic_credit_counter #(.CREDITS(CREDITS)) u_credit (
        .clock   (clock),
        .reset_n (reset_n),
        .i_take  (w_accept),
        .i_give  (credit_return),
        .o_ready (in_ready),
        .o_err   (credit_err)
    );

`ifdef CORDIC_FEED_DITHER_EN
    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, stepped once per accepted sample.
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;

    assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_lfsr <= 16'hACE1;
        end else if (w_accept) begin
            r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
        end
    end

    // Two LSBs taken as a signed 2-bit value, so the dither spans -2..+1.
    assign w_angle = in_angle + {{14{r_lfsr[1]}}, r_lfsr[1:0]};
`else
    assign w_angle = in_angle;
`endif

    // Input capture at the accepting edge.
    logic   r_cap_vld;
    angle_t r_cap_angle;

    // Stage A: angle plus the fold decision.
    logic   r_a_vld;
    logic   r_a_fold;
    angle_t r_a_angle;

    // Stage B: output vector; data only loads with a valid sample and holds otherwise.
    logic    r_b_vld;
    sample_t r_x;
    angle_t  r_z;
    angle_t  r_c;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cap_vld   <= 1'b0;
            r_cap_angle <= '0;
            r_a_vld     <= 1'b0;
            r_a_fold    <= 1'b0;
            r_a_angle   <= '0;
            r_b_vld     <= 1'b0;
            r_x         <= '0;
            r_z         <= '0;
            r_c         <= '0;
        end else begin
            r_cap_vld <= w_accept;
            if (w_accept) begin
                r_cap_angle <= w_angle;
            end

            r_a_vld   <= r_cap_vld;
            r_a_fold  <= needs_fold(r_cap_angle);
            r_a_angle <= r_cap_angle;

            r_b_vld <= r_a_vld;
            if (r_a_vld) begin
                // Rotating by pi flips the sign of the starting vector.
                r_z <= r_a_fold ? (r_a_angle - ANGLE_PI) : r_a_angle;
                r_x <= r_a_fold ? (~AMPLITUDE + 16'd1) : AMPLITUDE;
                r_c <= C0;
            end
        end
    end

    assign valid_out = r_b_vld;
    assign x_out     = r_x;
    assign z_out     = r_z;
    assign c_out     = r_c;
    assign y_out     = 16'h0000;
    assign k_out     = 16'h0000;

endmodule

// File: tb/tb_cordic_feed.sv
// Self-checking bench for cordic_feed (CREDITS=4) against a behavioural fold/credit model.
// Latency: n/a. Backpressure: bench honours in_ready through the model's credit count.
// Outputs are sampled on the falling clock edge; inputs change on the falling edge.
module tb_cordic_feed;

    localparam int CRED = 4;
    localparam int AMP  = 'h4DBA;
    localparam int CZ   = 'h2000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] in_angle = 16'h0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        credit_return = 1'b0;
    logic [15:0] k_out, c_out, x_out, y_out, z_out;
    logic        valid_out, credit_err;

    cordic_feed #(.CREDITS(CRED)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_angle      (in_angle),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .credit_return (credit_return),
        .k_out         (k_out),
        .c_out         (c_out),
        .x_out         (x_out),
        .y_out         (y_out),
        .z_out         (z_out),
        .valid_out     (valid_out),
        .credit_err    (credit_err)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    int mcred;
    bit merr;
    int edge_no = 0;
    int pend_angle[$];
    int pend_due[$];
    int last_x, last_z, last_c;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ref_z(input int a);
        if (a > 'h4000 && a < 'hC000) return (a - 'h8000) & 'hFFFF;
        return a;
    endfunction

    function automatic int ref_x(input int a);
        if (a > 'h4000 && a < 'hC000) return ('h10000 - AMP) & 'hFFFF;
        return AMP;
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        in_valid = 1'b0;
        credit_return = 1'b0;
        pend_angle.delete();
        pend_due.delete();
        mcred = CRED;
        merr = 1'b0;
        last_x = 0; last_z = 0; last_c = 0;
        #1;
        chk("rst_valid", valid_out, 0);
        chk("rst_x", x_out, 0);
        chk("rst_z", z_out, 0);
        chk("rst_c", c_out, 0);
        chk("rst_err", credit_err, 0);
        chk("rst_ready", in_ready, 1);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // One clock: drive inputs, check ready, update model at the edge, check outputs after it.
    task automatic cycle(input bit v, input int a, input bit r, output bit took);
        bit acc;
        in_valid = v;
        in_angle = a[15:0];
        credit_return = r;
        #1;
        chk("in_ready", in_ready, (mcred != 0));
        took = v && in_ready;
        acc = v && (mcred != 0);
        @(posedge clock);
        edge_no++;
        if (acc) begin
            pend_angle.push_back(a);
            pend_due.push_back(edge_no + 2);
        end
        if (acc && !r) mcred--;
        else if (r && !acc) begin
            if (mcred == CRED) merr = 1'b1;
            else mcred++;
        end
        @(negedge clock);
        chk("credit_err", credit_err, merr);
        chk("y_out", y_out, 0);
        chk("k_out", k_out, 0);
        if (pend_due.size() > 0 && pend_due[0] == edge_no) begin
            int ea;
            ea = pend_angle.pop_front();
            void'(pend_due.pop_front());
            last_x = ref_x(ea);
            last_z = ref_z(ea);
            last_c = CZ;
            chk("valid_out", valid_out, 1);
        end else begin
            chk("valid_idle", valid_out, 0);
        end
        chk("x_out", x_out, last_x);
        chk("z_out", z_out, last_z);
        chk("c_out", c_out, last_c);
    endtask

    int dir_angles[9] = '{'h0000, 'h6000, 'h8000, 'h4000, 'hC000, 'h4001, 'hBFFF, 'h3FFF, 'hC001};

    initial begin
        bit t;
        int cnt;
        #2;
        do_reset();

        // Directed fold cases, returning each credit right after use.
        foreach (dir_angles[i]) begin
            cycle(1'b1, dir_angles[i], 1'b0, t);
            cycle(1'b0, 0, 1'b1, t);
        end
        repeat (3) cycle(1'b0, 0, 1'b0, t);

        // Credit exhaustion with in_valid held high.
        do_reset();
        cnt = 0;
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, 'h1000 + i, 1'b0, t);
            cnt += int'(t);
        end
        chk("burst_accepts", cnt, CRED);
        cycle(1'b0, 0, 1'b1, t);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 'h2000 + i, 1'b0, t);
            cnt += int'(t);
        end
        chk("one_more_accept", cnt, 1);
        // Accept coincident with return leaves one credit.
        cycle(1'b0, 0, 1'b1, t);
        cycle(1'b1, 'h7000, 1'b1, t);
        cycle(1'b1, 'h9000, 1'b0, t);
        cycle(1'b1, 'hA000, 1'b0, t);
        chk("coincident_no_extra", t, 0);
        // Refill, then one surplus return.
        repeat (CRED) cycle(1'b0, 0, 1'b1, t);
        cycle(1'b0, 0, 1'b1, t);
        repeat (4) cycle(1'b0, 0, 1'b0, t);
        chk("err_sticky", credit_err, 1);
        do_reset();

        // Reset while two samples are in flight.
        cycle(1'b1, 'h6000, 1'b0, t);
        cycle(1'b1, 'h1234, 1'b0, t);
        do_reset();
        repeat (5) cycle(1'b0, 0, 1'b0, t);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            int a;
            if ($urandom_range(3) == 0) a = dir_angles[$urandom_range(8)];
            else a = int'($urandom_range(16'hFFFF));
            cycle(1'($urandom_range(3) != 0), a, 1'($urandom_range(2) == 0), t);
        end
        repeat (4) cycle(1'b0, 0, 1'b0, t);
        chk("drained", pend_due.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
